// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Stage count at which the sequencer leaves RELEASE for RUN.
  function automatic int release_span(input int num_domains, input int stage_cycles);
    return (num_domains + 1) * stage_cycles;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for signals crossing into the local clock.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings up the system PLL, qualifies lock and releases domain resets in staggered order.
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int NUM_DOMAINS         = 3,
  parameter int STAGE_CYCLES        = 8,
  parameter int CNT_W               = 8
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  input  logic                   relock_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [CNT_W-1:0]       relock_count,
  output logic [CNT_W-1:0]       timeout_count
);

  localparam int CYC_W = cnt_bits(PLL_RST_CYCLES);
  localparam int STB_W = cnt_bits(LOCK_STABLE_CYCLES);
  localparam int TMO_W = cnt_bits(LOCK_TIMEOUT_CYCLES);
  localparam int STG_W = cnt_bits(release_span(NUM_DOMAINS, STAGE_CYCLES));

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_DONE = TMO_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [STG_W-1:0] STG_DONE = STG_W'(release_span(NUM_DOMAINS, STAGE_CYCLES));
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  pll_state_e               state;
  logic                     locked_s;
  logic [CYC_W-1:0]         cyc_cnt;
  logic [STB_W-1:0]         stable_cnt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic [STG_W-1:0]         stage_cnt;
  logic [STB_W-1:0]         stable_nxt;
  logic [TMO_W-1:0]         tmo_nxt;
  logic [STG_W-1:0]         stage_nxt;
  logic [NUM_DOMAINS-1:0]   domain_hold;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Next counter values; lock and timeout decisions look at the value this edge would store.
  always_comb begin
    stable_nxt = locked_s ? (stable_cnt + STB_W'(1)) : '0;
    tmo_nxt    = tmo_cnt + TMO_W'(1);
    stage_nxt  = stage_cnt + STG_W'(1);
    domain_hold = '1;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      domain_hold[i] = (stage_nxt < STG_W'((i + 1) * STAGE_CYCLES));
    end
  end

  // Sequencer FSM with registered outputs and saturating status counters.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state         <= PLL_RST;
      cyc_cnt       <= '0;
      stable_cnt    <= '0;
      tmo_cnt       <= '0;
      stage_cnt     <= '0;
      pll_rst       <= 1'b1;
      domain_rst    <= '1;
      ready         <= 1'b0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cyc_cnt == CYC_LAST) begin
            state      <= WAIT_LOCK;
            pll_rst    <= 1'b0;
            cyc_cnt    <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock takes priority when it qualifies on the same edge as the timeout.
          if (stable_nxt == STB_DONE) begin
            state     <= RELEASE;
            stage_cnt <= '0;
          end else if (tmo_nxt == TMO_DONE) begin
            state   <= PLL_RST;
            pll_rst <= 1'b1;
            cyc_cnt <= '0;
            if (timeout_count != CNT_MAX) begin
              timeout_count <= timeout_count + CNT_W'(1);
            end
          end else begin
            stable_cnt <= stable_nxt;
            tmo_cnt    <= tmo_nxt;
          end
        end
        RELEASE: begin
          if (!locked_s) begin
            state      <= PLL_RST;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            cyc_cnt    <= '0;
            if (relock_count != CNT_MAX) begin
              relock_count <= relock_count + CNT_W'(1);
            end
          end else if (stage_nxt == STG_DONE) begin
            state      <= RUN;
            ready      <= 1'b1;
            domain_rst <= '0;
          end else begin
            stage_cnt  <= stage_nxt;
            domain_rst <= domain_hold;
          end
        end
        RUN: begin
          if (!locked_s || relock_req) begin
            state      <= PLL_RST;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            cyc_cnt    <= '0;
            if (!locked_s && (relock_count != CNT_MAX)) begin
              relock_count <= relock_count + CNT_W'(1);
            end
          end
        end
        default: begin
          state      <= PLL_RST;
          pll_rst    <= 1'b1;
          domain_rst <= '1;
          ready      <= 1'b0;
          cyc_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized bench for pll_reset_sequencer against a time-based reference model.
module tb_pll_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_STB = 8;
  localparam int P_TMO = 32;
  localparam int P_STG = 2;
  localparam int P_ND  = 3;
  localparam int P_CW  = 8;

  logic            refclk;
  logic            rst;
  logic            locked;
  logic            relock_req;
  logic            pll_rst;
  logic [P_ND-1:0] domain_rst;
  logic            ready;
  logic [P_CW-1:0] relock_count;
  logic [P_CW-1:0] timeout_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: time since attempt start, run of high locked_s, time since release.
  int m_att;
  int m_run;
  int m_rel;
  int m_relock;
  int m_tmo;
  logic m_s1;
  logic m_s2;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_STABLE_CYCLES  (P_STB),
    .LOCK_TIMEOUT_CYCLES (P_TMO),
    .NUM_DOMAINS         (P_ND),
    .STAGE_CYCLES        (P_STG),
    .CNT_W               (P_CW)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .locked        (locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .domain_rst    (domain_rst),
    .ready         (ready),
    .relock_count  (relock_count),
    .timeout_count (timeout_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_reset();
    m_att = 0; m_run = 0; m_rel = -1; m_relock = 0; m_tmo = 0; m_s1 = 1'b0; m_s2 = 1'b0;
  endtask

  task automatic model_restart();
    m_att = 0; m_run = 0; m_rel = -1;
  endtask

  task automatic model_step();
    logic ls;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = locked;
    if (m_rel >= 0) begin
      if (!ls) begin
        m_relock = sat(m_relock);
        model_restart();
      end else if (m_rel >= (P_ND + 1) * P_STG && relock_req) begin
        model_restart();
      end else if (m_rel < (P_ND + 1) * P_STG) begin
        m_rel++;
      end
    end else if (m_att < P_RST) begin
      m_att++;
    end else begin
      m_run = ls ? m_run + 1 : 0;
      if (m_run == P_STB) m_rel = 0;
      else if (m_att - P_RST + 1 == P_TMO) begin
        m_tmo = sat(m_tmo);
        model_restart();
      end else m_att++;
    end
  endtask

  function automatic logic [20:0] model_out();
    logic [2:0] dom;
    logic pr;
    logic rdy;
    pr  = (m_rel < 0) && (m_att < P_RST);
    rdy = (m_rel >= (P_ND + 1) * P_STG);
    dom = 3'b111;
    if (m_rel >= 0) begin
      for (int i = 0; i < P_ND; i++) dom[i] = (m_rel < P_STG * (i + 1));
    end
    return {pr, dom, rdy, 8'(m_relock), 8'(m_tmo)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
    chk("model", {11'd0, pll_rst, domain_rst, ready, relock_count, timeout_count}, {11'd0, model_out()});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n;
    n = 0;
    while (!ready && n < bound) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; locked = 1'b0; relock_req = 1'b0;
    model_reset();
    repeat (2) @(negedge refclk);
    chk("reset_vals", {11'd0, pll_rst, domain_rst, ready, relock_count, timeout_count},
        {11'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0});
    rst = 1'b0;

    // Clean bring-up: locked rises 10 cycles after pll_rst falls.
    ticks(3);
    chk("pll_rst_held", {31'd0, pll_rst}, 32'd1);
    tick();
    chk("pll_rst_fall", {31'd0, pll_rst}, 32'd0);
    ticks(10);
    locked = 1'b1;
    ticks(11);
    chk("dom_111", {29'd0, domain_rst}, 32'd7);
    tick();
    chk("dom_110", {29'd0, domain_rst}, 32'd6);
    ticks(2);
    chk("dom_100", {29'd0, domain_rst}, 32'd4);
    ticks(2);
    chk("dom_000", {29'd0, domain_rst}, 32'd0);
    tick();
    chk("ready_early", {31'd0, ready}, 32'd0);
    tick();
    chk("ready_at_8", {31'd0, ready}, 32'd1);
    chk("counters_zero", {16'd0, relock_count, timeout_count}, 32'd0);

    // Lock loss in RUN: response three edges after locked falls.
    locked = 1'b0;
    ticks(2);
    chk("loss_not_yet", {31'd0, ready}, 32'd1);
    tick();
    chk("loss_resp", {26'd0, pll_rst, domain_rst, ready}, {26'd0, 1'b1, 3'b111, 1'b0});
    chk("relock_1", {24'd0, relock_count}, 32'd1);
    locked = 1'b1;
    wait_ready("reseq_ready", 80);

    // Relock request in RUN resequences without counting.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("req_resp", {31'd0, pll_rst}, 32'd1);
    chk("req_nocount", {24'd0, relock_count}, 32'd1);
    ticks(4);
    chk("req_pll_fall", {31'd0, pll_rst}, 32'd0);
    // Ignored request in WAIT_LOCK plus a one-sample lock glitch after 5 high samples.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    ticks(2);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    n = 0;
    while (!ready && n < 60) begin
      tick();
      n++;
    end
    chk("glitch_delay", n, 32'd18);

    // Request coincident with lock loss is counted.
    locked = 1'b0;
    ticks(2);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("simul_count", {24'd0, relock_count}, 32'd2);
    chk("simul_resp", {31'd0, pll_rst}, 32'd1);
    locked = 1'b1;
    wait_ready("simul_ready", 80);

    // Randomized lock activity and relock requests.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(47, 0) == 0) locked = ~locked;
      relock_req = ($urandom_range(23, 0) == 0);
      tick();
    end
    relock_req = 1'b0;
    locked = 1'b1;

    // Asynchronous reset in the middle of RELEASE.
    n = 0;
    while (m_rel != 2 * P_STG && n < 300) begin
      tick();
      n++;
    end
    chk("mid_release", {29'd0, domain_rst}, 32'd4);
    rst = 1'b1;
    #1;
    chk("async_rst", {11'd0, pll_rst, domain_rst, ready, relock_count, timeout_count},
        {11'd0, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0});
    model_reset();
    @(posedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    locked = 1'b0;

    // Timeout retries and saturation of timeout_count.
    ticks(P_RST + P_TMO);
    chk("tmo_first", {24'd0, timeout_count}, 32'd1);
    chk("tmo_pll_rst", {31'd0, pll_rst}, 32'd1);
    ticks(254 * (P_RST + P_TMO));
    chk("tmo_255", {24'd0, timeout_count}, 32'd255);
    ticks(2 * (P_RST + P_TMO));
    chk("tmo_sat", {24'd0, timeout_count}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
